// File: rtl/tlb_op_unit.sv
// tlb_op_unit: sequences TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB onto the 16-entry TLB array ports.
// Macro TLB_FILL_RR_EN selects a round-robin FILL pointer; otherwise a free-running counter picks the FILL slot.
module tlb_op_unit #(
   parameter int TLBNUM = 16,
   localparam int IDXW = $clog2(TLBNUM)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            op_valid,
   output logic            op_ready,
   input  logic [2:0]      op_code,
   input  logic [4:0]      op_inv,
   input  logic [9:0]      op_asid,
   input  logic [31:0]     op_va,
   input  logic [31:0]     csr_tlbidx,
   input  logic [31:0]     csr_tlbehi,
   input  logic [31:0]     csr_tlbelo0,
   input  logic [31:0]     csr_tlbelo1,
   input  logic [9:0]      csr_asid,
   input  logic [5:0]      csr_ecode,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic            resp_ine,
   output logic            resp_idx_we,
   output logic            resp_ehi_we,
   output logic [31:0]     resp_tlbidx,
   output logic [31:0]     resp_tlbehi,
   output logic [31:0]     resp_tlbelo0,
   output logic [31:0]     resp_tlbelo1,
   output logic [9:0]      resp_asid,
   output logic [18:0]     s1_vppn,
   output logic            s1_va_bit12,
   output logic [9:0]      s1_asid,
   input  logic            s1_found,
   input  logic [IDXW-1:0] s1_index,
   output logic            invtlb_valid,
   output logic [4:0]      invtlb_op,
   output logic            we,
   output logic [IDXW-1:0] w_index,
   output logic            w_e,
   output logic [18:0]     w_vppn,
   output logic [5:0]      w_ps,
   output logic [9:0]      w_asid,
   output logic            w_g,
   output logic [19:0]     w_ppn0,
   output logic [1:0]      w_plv0,
   output logic [1:0]      w_mat0,
   output logic            w_d0,
   output logic            w_v0,
   output logic [19:0]     w_ppn1,
   output logic [1:0]      w_plv1,
   output logic [1:0]      w_mat1,
   output logic            w_d1,
   output logic            w_v1,
   output logic [IDXW-1:0] r_index,
   input  logic            r_e,
   input  logic [18:0]     r_vppn,
   input  logic [5:0]      r_ps,
   input  logic [9:0]      r_asid,
   input  logic            r_g,
   input  logic [19:0]     r_ppn0,
   input  logic [1:0]      r_plv0,
   input  logic [1:0]      r_mat0,
   input  logic            r_d0,
   input  logic            r_v0,
   input  logic [19:0]     r_ppn1,
   input  logic [1:0]      r_plv1,
   input  logic [1:0]      r_mat1,
   input  logic            r_d1,
   input  logic            r_v1
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd2} state_e;
   localparam logic [2:0] OP_SRCH = 3'd0;
   localparam logic [2:0] OP_RD   = 3'd1;
   localparam logic [2:0] OP_WR   = 3'd2;
   localparam logic [2:0] OP_FILL = 3'd3;
   localparam logic [2:0] OP_INV  = 3'd4;

   state_e          state_q, state_d;
   logic [2:0]      code_q;
   logic [4:0]      inv_q;
   logic [9:0]      opasid_q;
   logic [18:0]     va_vppn_q;
   logic [31:0]     idx_q;
   logic [18:0]     ehi_vppn_q;
   logic [31:0]     elo0_q, elo1_q;
   logic [9:0]      casid_q;
   logic [5:0]      ecode_q;
   logic [IDXW-1:0] fill_idx;

   logic            ine_d, iwe_d, ewe_d;
   logic [31:0]     idx_d, ehi_d, elo0_d, elo1_d;
   logic [9:0]      asid_d;
   logic            ine_q, iwe_q, ewe_q;
   logic [31:0]     ridx_q, rehi_q, relo0_q, relo1_q;
   logic [9:0]      rasid_q;

   logic accept, exec, ine;
   logic unused_bits;

   assign accept = op_valid && (state_q == S_IDLE);
   assign exec   = (state_q == S_EXEC);
   assign ine    = (code_q > OP_INV) || ((code_q == OP_INV) && (inv_q > 5'd6));
   assign unused_bits = ^{op_va[12:0], csr_tlbehi[12:0], elo0_q[31:28], elo0_q[7],
                          elo1_q[31:28], elo1_q[7]};

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_EXEC;
         S_EXEC:  state_d = S_DONE;
         S_DONE:  if (resp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Operands are captured once at accept; later CSR traffic cannot disturb the op.
   always_ff @(posedge clk) begin
      if (accept) begin
         code_q     <= op_code;
         inv_q      <= op_inv;
         opasid_q   <= op_asid;
         va_vppn_q  <= op_va[31:13];
         idx_q      <= csr_tlbidx;
         ehi_vppn_q <= csr_tlbehi[31:13];
         elo0_q     <= csr_tlbelo0;
         elo1_q     <= csr_tlbelo1;
         casid_q    <= csr_asid;
         ecode_q    <= csr_ecode;
      end
   end

`ifdef TLB_FILL_RR_EN
   logic [IDXW-1:0] ptr_q, ptr_d;
   assign ptr_d = (ptr_q == IDXW'(TLBNUM - 1)) ? '0 : ptr_q + IDXW'(1);
   always_ff @(posedge clk) begin
      if (reset)                            ptr_q <= '0;
      else if (exec && code_q == OP_FILL)   ptr_q <= ptr_d;
   end
   assign fill_idx = ptr_q;
`else
   logic [IDXW-1:0] cnt_q, cnt_d, fidx_q;
   assign cnt_d = (cnt_q == IDXW'(TLBNUM - 1)) ? '0 : cnt_q + IDXW'(1);
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         fidx_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (accept) fidx_q <= cnt_q;
      end
   end
   assign fill_idx = fidx_q;
`endif

   // Response images are built from the array's answers during EXEC.
   always_comb begin
      ine_d  = 1'b0;
      iwe_d  = 1'b0;
      ewe_d  = 1'b0;
      idx_d  = idx_q;
      ehi_d  = '0;
      elo0_d = '0;
      elo1_d = '0;
      asid_d = '0;
      if (ine) begin
         ine_d = 1'b1;
      end else begin
         case (code_q)
            OP_SRCH: begin
               iwe_d = 1'b1;
               if (s1_found) begin
                  idx_d[IDXW-1:0] = s1_index;
                  idx_d[31]       = 1'b0;
               end else begin
                  idx_d[31] = 1'b1;
               end
            end
            OP_RD: begin
               iwe_d = 1'b1;
               ewe_d = 1'b1;
               if (r_e) begin
                  idx_d[31]    = 1'b0;
                  idx_d[29:24] = r_ps;
                  ehi_d        = {r_vppn, 13'b0};
                  elo0_d       = {4'b0, r_ppn0, 1'b0, r_g, r_mat0, r_plv0, r_d0, r_v0};
                  elo1_d       = {4'b0, r_ppn1, 1'b0, r_g, r_mat1, r_plv1, r_d1, r_v1};
                  asid_d       = r_asid;
               end else begin
                  idx_d[31]    = 1'b1;
                  idx_d[29:24] = 6'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ine_q   <= 1'b0;
         iwe_q   <= 1'b0;
         ewe_q   <= 1'b0;
         ridx_q  <= '0;
         rehi_q  <= '0;
         relo0_q <= '0;
         relo1_q <= '0;
         rasid_q <= '0;
      end else if (exec) begin
         ine_q   <= ine_d;
         iwe_q   <= iwe_d;
         ewe_q   <= ewe_d;
         ridx_q  <= idx_d;
         rehi_q  <= ehi_d;
         relo0_q <= elo0_d;
         relo1_q <= elo1_d;
         rasid_q <= asid_d;
      end
   end

   always_comb begin
      op_ready     = (state_q == S_IDLE);
      resp_valid   = (state_q == S_DONE);
      resp_ine     = ine_q;
      resp_idx_we  = iwe_q;
      resp_ehi_we  = ewe_q;
      resp_tlbidx  = ridx_q;
      resp_tlbehi  = rehi_q;
      resp_tlbelo0 = relo0_q;
      resp_tlbelo1 = relo1_q;
      resp_asid    = rasid_q;
      s1_va_bit12  = 1'b0;
      s1_vppn      = (code_q == OP_INV) ? va_vppn_q : ehi_vppn_q;
      s1_asid      = (code_q == OP_INV) ? opasid_q : casid_q;
      // Strobes are cut by reset so an op caught mid-flight leaves the array untouched.
      invtlb_valid = exec && !ine && (code_q == OP_INV) && !reset;
      invtlb_op    = inv_q;
      we           = exec && !ine && ((code_q == OP_WR) || (code_q == OP_FILL)) && !reset;
      w_index      = (code_q == OP_FILL) ? fill_idx : idx_q[IDXW-1:0];
      w_e          = (ecode_q == 6'h3F) ? 1'b1 : !idx_q[31];
      w_vppn       = ehi_vppn_q;
      w_ps         = idx_q[29:24];
      w_asid       = casid_q;
      w_g          = elo0_q[6] & elo1_q[6];
      w_ppn0       = elo0_q[27:8];
      w_plv0       = elo0_q[3:2];
      w_mat0       = elo0_q[5:4];
      w_d0         = elo0_q[1];
      w_v0         = elo0_q[0];
      w_ppn1       = elo1_q[27:8];
      w_plv1       = elo1_q[3:2];
      w_mat1       = elo1_q[5:4];
      w_d1         = elo1_q[1];
      w_v1         = elo1_q[0];
      r_index      = idx_q[IDXW-1:0];
   end

endmodule

// File: tb/tb_tlb_op_unit.sv
// Scoreboard bench for tlb_op_unit with a behavioural 16-entry TLB array attached to its ports.
`timescale 1ns/1ps
module tb_tlb_op_unit;
   localparam int TLBNUM = 16;
   localparam int IDXW   = 4;

   typedef struct packed {
      logic e; logic [18:0] vppn; logic [5:0] ps; logic [9:0] asid; logic g;
      logic [19:0] ppn0; logic [1:0] plv0; logic [1:0] mat0; logic d0; logic v0;
      logic [19:0] ppn1; logic [1:0] plv1; logic [1:0] mat1; logic d1; logic v1;
   } tlbe_t;
   typedef struct packed {
      logic ine, iwe, ewe, cmp_idx, full;
      logic [31:0] idx, ehi, e0, e1;
      logic [9:0] asid;
   } rsp_t;
   typedef struct packed {
      logic inv; logic [IDXW-1:0] index; tlbe_t ent;
      logic [4:0] iop; logic [18:0] vppn; logic [9:0] asid;
   } stb_t;

   logic clk, reset, op_valid, op_ready, resp_valid, resp_ready;
   logic [2:0] op_code; logic [4:0] op_inv; logic [9:0] op_asid; logic [31:0] op_va;
   logic [31:0] csr_tlbidx, csr_tlbehi, csr_tlbelo0, csr_tlbelo1;
   logic [9:0] csr_asid; logic [5:0] csr_ecode;
   logic resp_ine, resp_idx_we, resp_ehi_we;
   logic [31:0] resp_tlbidx, resp_tlbehi, resp_tlbelo0, resp_tlbelo1; logic [9:0] resp_asid;
   logic [18:0] s1_vppn; logic s1_va_bit12; logic [9:0] s1_asid;
   logic s1_found; logic [IDXW-1:0] s1_index;
   logic invtlb_valid; logic [4:0] invtlb_op;
   logic we, w_e, w_g, w_d0, w_v0, w_d1, w_v1; logic [IDXW-1:0] w_index;
   logic [18:0] w_vppn; logic [5:0] w_ps; logic [9:0] w_asid;
   logic [19:0] w_ppn0, w_ppn1; logic [1:0] w_plv0, w_mat0, w_plv1, w_mat1;
   logic [IDXW-1:0] r_index;
   logic r_e, r_g, r_d0, r_v0, r_d1, r_v1; logic [18:0] r_vppn; logic [5:0] r_ps; logic [9:0] r_asid;
   logic [19:0] r_ppn0, r_ppn1; logic [1:0] r_plv0, r_mat0, r_plv1, r_mat1;

   tlb_op_unit #(.TLBNUM(TLBNUM)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
      .op_code(op_code), .op_inv(op_inv), .op_asid(op_asid), .op_va(op_va),
      .csr_tlbidx(csr_tlbidx), .csr_tlbehi(csr_tlbehi), .csr_tlbelo0(csr_tlbelo0),
      .csr_tlbelo1(csr_tlbelo1), .csr_asid(csr_asid), .csr_ecode(csr_ecode),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_ine(resp_ine),
      .resp_idx_we(resp_idx_we), .resp_ehi_we(resp_ehi_we), .resp_tlbidx(resp_tlbidx),
      .resp_tlbehi(resp_tlbehi), .resp_tlbelo0(resp_tlbelo0), .resp_tlbelo1(resp_tlbelo1),
      .resp_asid(resp_asid), .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
      .s1_found(s1_found), .s1_index(s1_index), .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op),
      .we(we), .w_index(w_index), .w_e(w_e), .w_vppn(w_vppn), .w_ps(w_ps), .w_asid(w_asid),
      .w_g(w_g), .w_ppn0(w_ppn0), .w_plv0(w_plv0), .w_mat0(w_mat0), .w_d0(w_d0), .w_v0(w_v0),
      .w_ppn1(w_ppn1), .w_plv1(w_plv1), .w_mat1(w_mat1), .w_d1(w_d1), .w_v1(w_v1),
      .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps), .r_asid(r_asid), .r_g(r_g),
      .r_ppn0(r_ppn0), .r_plv0(r_plv0), .r_mat0(r_mat0), .r_d0(r_d0), .r_v0(r_v0),
      .r_ppn1(r_ppn1), .r_plv1(r_plv1), .r_mat1(r_mat1), .r_d1(r_d1), .r_v1(r_v1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int we_cnt = 0;
   rsp_t rsp_q[$];
   stb_t strb_q[$];
   rsp_t mr;
   stb_t ms;
   tlbe_t env [TLBNUM];
   tlbe_t refm [TLBNUM];
   logic [IDXW-1:0] rr_exp;
`ifndef TLB_FILL_RR_EN
   logic [IDXW-1:0] tb_cnt;
   always @(posedge clk) tb_cnt <= reset ? '0 : tb_cnt + 1'b1;
`endif

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   // Behavioural TLB array driven by the DUT's write port.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < TLBNUM; i++) env[i].e <= 1'b0;
      end else if (we) begin
         env[w_index] <= {w_e, w_vppn, w_ps, w_asid, w_g, w_ppn0, w_plv0, w_mat0, w_d0, w_v0,
                          w_ppn1, w_plv1, w_mat1, w_d1, w_v1};
      end
   end
   assign r_e = env[r_index].e;       assign r_vppn = env[r_index].vppn;
   assign r_ps = env[r_index].ps;     assign r_asid = env[r_index].asid;
   assign r_g = env[r_index].g;
   assign r_ppn0 = env[r_index].ppn0; assign r_plv0 = env[r_index].plv0;
   assign r_mat0 = env[r_index].mat0; assign r_d0 = env[r_index].d0; assign r_v0 = env[r_index].v0;
   assign r_ppn1 = env[r_index].ppn1; assign r_plv1 = env[r_index].plv1;
   assign r_mat1 = env[r_index].mat1; assign r_d1 = env[r_index].d1; assign r_v1 = env[r_index].v1;

   always_comb begin
      s1_found = 1'b0;
      s1_index = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
         if (env[i].e && env[i].vppn == s1_vppn && (env[i].g || env[i].asid == s1_asid)) begin
            s1_found = 1'b1;
            s1_index = IDXW'(i);
         end
      end
   end

   function automatic int ref_find(input logic [18:0] vppn, input logic [9:0] asid);
      for (int i = 0; i < TLBNUM; i++)
         if (refm[i].e && refm[i].vppn == vppn && (refm[i].g || refm[i].asid == asid)) return i;
      return -1;
   endfunction

   function automatic tlbe_t mk_ent(input logic [31:0] idx, ehi, e0, e1,
                                    input logic [9:0] casid, input logic [5:0] ecode);
      tlbe_t t;
      t.e = (ecode == 6'h3F) ? 1'b1 : ~idx[31];
      t.vppn = ehi[31:13]; t.ps = idx[29:24]; t.asid = casid; t.g = e0[6] & e1[6];
      t.ppn0 = e0[27:8]; t.mat0 = e0[5:4]; t.plv0 = e0[3:2]; t.d0 = e0[1]; t.v0 = e0[0];
      t.ppn1 = e1[27:8]; t.mat1 = e1[5:4]; t.plv1 = e1[3:2]; t.d1 = e1[1]; t.v1 = e1[0];
      return t;
   endfunction

   function automatic logic [31:0] elo_img(input logic [19:0] ppn, input logic g, input logic [1:0] mat,
                                           input logic [1:0] plv, input logic d, input logic v);
      return {4'b0, ppn, 1'b0, g, mat, plv, d, v};
   endfunction

   // Response checker: compares on the cycle the response is taken.
   always @(negedge clk) begin
      if (!reset && resp_valid && resp_ready) begin
         if (rsp_q.size() == 0) chk("unexpected_resp", 1, 0);
         else begin
            mr = rsp_q.pop_front();
            chk("resp_ine", resp_ine, mr.ine);
            chk("resp_idx_we", resp_idx_we, mr.iwe);
            chk("resp_ehi_we", resp_ehi_we, mr.ewe);
            if (mr.cmp_idx) chk("resp_tlbidx", resp_tlbidx, mr.idx);
            if (mr.full) begin
               chk("resp_tlbehi", resp_tlbehi, mr.ehi);
               chk("resp_tlbelo0", resp_tlbelo0, mr.e0);
               chk("resp_tlbelo1", resp_tlbelo1, mr.e1);
               chk("resp_asid", resp_asid, mr.asid);
            end
         end
      end
   end

   // Strobe checker: every we/invtlb pulse must match a queued expectation.
   always @(negedge clk) begin
      if (we && invtlb_valid) chk("we_and_invtlb", 1, 0);
      if (we) we_cnt++;
      if (we || invtlb_valid) begin
         if (strb_q.size() == 0) chk("unexpected_strobe", {we, invtlb_valid}, 0);
         else begin
            ms = strb_q.pop_front();
            chk("strobe_kind", {we, invtlb_valid}, ms.inv ? 2'b01 : 2'b10);
            if (!ms.inv) begin
               chk("w_index", w_index, ms.index);
               chk("w_entry", {w_e, w_vppn, w_ps, w_asid, w_g, w_ppn0, w_plv0, w_mat0, w_d0, w_v0,
                               w_ppn1, w_plv1, w_mat1, w_d1, w_v1}, ms.ent);
            end else begin
               chk("invtlb_op", invtlb_op, ms.iop);
               chk("inv_vppn", s1_vppn, ms.vppn);
               chk("inv_asid", s1_asid, ms.asid);
            end
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      op_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < TLBNUM; i++) refm[i] = '0;
      rr_exp = '0;
      reset = 1'b0;
   endtask

   task automatic issue_op(input logic [2:0] code, input logic [4:0] inv, input logic [9:0] oasid,
                           input logic [31:0] va, idx, ehi, e0, e1,
                           input logic [9:0] casid, input logic [5:0] ecode, input bit push);
      int n, h;
      logic [IDXW-1:0] fill_exp;
      rsp_t r;
      stb_t s;
      tlbe_t t;
      bit ine, have_s;
      @(posedge clk); #1;
      op_code = code; op_inv = inv; op_asid = oasid; op_va = va;
      csr_tlbidx = idx; csr_tlbehi = ehi; csr_tlbelo0 = e0; csr_tlbelo1 = e1;
      csr_asid = casid; csr_ecode = ecode; op_valid = 1'b1;
      n = 0;
      while (!op_ready && n < 20) begin @(posedge clk); #1; n++; end
`ifdef TLB_FILL_RR_EN
      fill_exp = rr_exp;
`else
      fill_exp = tb_cnt;
`endif
      @(posedge clk); #1;
      op_valid = 1'b0;
      csr_tlbidx = $urandom; csr_tlbehi = $urandom; csr_tlbelo0 = $urandom; csr_tlbelo1 = $urandom;
      csr_asid = 10'($urandom); csr_ecode = 6'($urandom); op_va = $urandom; op_asid = 10'($urandom);
      if (n == 20) begin chk("accept_timeout", 0, 1); return; end
      if (!push) return;
      ine = (code > 3'd4) || (code == 3'd4 && inv > 5'd6);
      r = '0; r.ine = ine; r.cmp_idx = 1'b1; r.idx = idx;
      s = '0; have_s = 1'b0;
      if (ine) r.cmp_idx = 1'b0;
      else begin
         case (code)
            3'd0: begin
               r.iwe = 1'b1;
               h = ref_find(ehi[31:13], casid);
               if (h >= 0) begin r.idx[IDXW-1:0] = h[IDXW-1:0]; r.idx[31] = 1'b0; end
               else r.idx[31] = 1'b1;
            end
            3'd1: begin
               t = refm[idx[IDXW-1:0]];
               r.iwe = 1'b1; r.ewe = 1'b1; r.full = 1'b1;
               if (t.e) begin
                  r.idx[31] = 1'b0; r.idx[29:24] = t.ps;
                  r.ehi = {t.vppn, 13'b0};
                  r.e0 = elo_img(t.ppn0, t.g, t.mat0, t.plv0, t.d0, t.v0);
                  r.e1 = elo_img(t.ppn1, t.g, t.mat1, t.plv1, t.d1, t.v1);
                  r.asid = t.asid;
               end else begin
                  r.idx[31] = 1'b1; r.idx[29:24] = 6'b0;
               end
            end
            3'd2, 3'd3: begin
               r.cmp_idx = 1'b0;
               s.inv = 1'b0;
               s.index = (code == 3'd2) ? idx[IDXW-1:0] : fill_exp;
               s.ent = mk_ent(idx, ehi, e0, e1, casid, ecode);
               refm[s.index] = s.ent;
               have_s = 1'b1;
               if (code == 3'd3) rr_exp = rr_exp + 1'b1;
            end
            default: begin
               r.cmp_idx = 1'b0;
               s.inv = 1'b1; s.iop = inv; s.vppn = va[31:13]; s.asid = oasid;
               have_s = 1'b1;
            end
         endcase
      end
      if (have_s) strb_q.push_back(s);
      rsp_q.push_back(r);
   endtask

   task automatic wait_resp();
      int n;
      n = 0;
      while (rsp_q.size() != 0 && n < 40) begin @(posedge clk); #1; n++; end
      if (n == 40) begin chk("resp_timeout", 0, 1); rsp_q.delete(); end
      chk("strobe_missing", strb_q.size(), 0);
      strb_q.delete();
   endtask

   task automatic run_op(input logic [2:0] code, input logic [4:0] inv, input logic [9:0] oasid,
                         input logic [31:0] va, idx, ehi, e0, e1,
                         input logic [9:0] casid, input logic [5:0] ecode);
      issue_op(code, inv, oasid, va, idx, ehi, e0, e1, casid, ecode, 1'b1);
      wait_resp();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] c;
      int base_we;
      resp_ready = 1'b1; op_valid = 1'b0; op_code = '0; op_inv = '0; op_asid = '0; op_va = '0;
      csr_tlbidx = '0; csr_tlbehi = '0; csr_tlbelo0 = '0; csr_tlbelo1 = '0;
      csr_asid = '0; csr_ecode = '0;
      do_reset();
      @(negedge clk);
      chk("rst_op_ready", op_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_we", we, 0);
      chk("rst_invtlb", invtlb_valid, 0);
      chk("rst_resp_fields", {resp_ine, resp_idx_we, resp_ehi_we, resp_tlbidx, resp_tlbehi,
                              resp_tlbelo0, resp_tlbelo1, resp_asid}, 0);

      // Entry at 5 for vppn 0x12345 / asid 0x2A, non-global, then hit and misses.
      run_op(3'd2, 5'd0, 10'd0, 32'd0, 32'h0C00_0005, {19'h12345, 13'h0},
             {4'h0, 20'h11111, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1},
             {4'h0, 20'h22222, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1}, 10'h2A, 6'h0);
      run_op(3'd0, 5'd0, 10'd0, 32'd0, 32'h0000_0009, {19'h12345, 13'h0}, 32'd0, 32'd0, 10'h2A, 6'h0);
      run_op(3'd0, 5'd0, 10'd0, 32'd0, 32'h0000_0009, {19'h12345, 13'h0}, 32'd0, 32'd0, 10'h2B, 6'h0);
      run_op(3'd0, 5'd0, 10'd0, 32'd0, 32'h0000_0009, {19'h54321, 13'h0}, 32'd0, 32'd0, 10'h2A, 6'h0);

      // WR at 3 with mismatched g bits, then read it back.
      run_op(3'd2, 5'd0, 10'd0, 32'd0, 32'h0D00_0003, {19'h0ABCD, 13'h0},
             {4'h0, 20'hABCDE, 1'b0, 1'b1, 2'b01, 2'b10, 1'b1, 1'b1},
             {4'h0, 20'h13579, 1'b0, 1'b0, 2'b10, 2'b11, 1'b0, 1'b1}, 10'h155, 6'h0);
      run_op(3'd1, 5'd0, 10'd0, 32'd0, 32'h0055_0003, 32'd0, 32'd0, 32'd0, 10'd0, 6'h0);

      // ne=1 with and without the refill ecode, then RD of the invalid entry.
      run_op(3'd2, 5'd0, 10'd0, 32'd0, 32'h8C00_0006, {19'h00066, 13'h0}, 32'h0000_0101,
             32'h0000_0201, 10'h3, 6'h3F);
      run_op(3'd2, 5'd0, 10'd0, 32'd0, 32'h8C00_0007, {19'h00077, 13'h0}, 32'h0000_0301,
             32'h0000_0401, 10'h3, 6'h00);
      run_op(3'd1, 5'd0, 10'd0, 32'd0, 32'h3F00_0007, 32'd0, 32'd0, 32'd0, 10'd0, 6'h0);

      // INVTLB illegal and legal, plus a reserved op code.
      run_op(3'd4, 5'd7, 10'h11, 32'hDEAD_B000, 32'd0, 32'd0, 32'd0, 32'd0, 10'd0, 6'h0);
      run_op(3'd4, 5'd5, 10'h11, 32'hDEAD_B000, 32'd0, 32'd0, 32'd0, 32'd0, 10'd0, 6'h0);
      run_op(3'd6, 5'd0, 10'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 10'd0, 6'h0);

      for (int k = 0; k < 10; k++) begin
         c = 3'($urandom_range(0, 2));
         run_op(c, 5'd0, 10'd0, 32'd0, $urandom, {19'(32'h12340 + $urandom_range(0, 3)), 13'h0},
                $urandom, $urandom, 10'($urandom_range(0, 3)), ($urandom_range(0, 1) != 0) ? 6'h3F : 6'h00);
      end

      // Response held back for 10 cycles.
      resp_ready = 1'b0;
      issue_op(3'd1, 5'd0, 10'd0, 32'd0, 32'h0000_0003, 32'd0, 32'd0, 32'd0, 10'd0, 6'h0, 1'b1);
      @(posedge clk);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("stall_resp_valid", resp_valid, 1);
         chk("stall_op_ready", op_ready, 0);
         if (rsp_q.size() == 0) chk("stall_no_expect", 0, 1);
         else begin
            chk("stall_tlbidx", resp_tlbidx, rsp_q[0].idx);
            chk("stall_tlbelo0", resp_tlbelo0, rsp_q[0].e0);
            chk("stall_tlbehi", resp_tlbehi, rsp_q[0].ehi);
         end
      end
      @(posedge clk); #1;
      resp_ready = 1'b1;
      wait_resp();

      // Four FILLs straight out of reset.
      do_reset();
      for (int k = 0; k < 4; k++)
         run_op(3'd3, 5'd0, 10'd0, 32'd0, $urandom & 32'h7FFF_FFFF, $urandom, $urandom, $urandom,
                10'($urandom), 6'h0);

      // Reset arriving during EXEC of a WR must swallow the write.
      base_we = we_cnt;
      issue_op(3'd2, 5'd0, 10'd0, 32'd0, 32'h0C00_0004, {19'h44444, 13'h0}, 32'h1, 32'h1,
               10'h4, 6'h0, 1'b0);
      do_reset();
      @(negedge clk);
      chk("rst_exec_op_ready", op_ready, 1);
      chk("rst_exec_resp_valid", resp_valid, 0);
      repeat (4) @(posedge clk);
      chk("rst_exec_no_we", we_cnt - base_we, 0);
      run_op(3'd0, 5'd0, 10'd0, 32'd0, 32'h0000_0004, {19'h44444, 13'h0}, 32'd0, 32'd0, 10'h4, 6'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
